// File: rtl/gat_bram_load_ctrl.sv
// gat_bram_load_ctrl: host-to-core BRAM loading bridge for the GAT accelerator.
// Packs BEATS consecutive 32-bit host writes per channel into one DATA_W-bit
// internal BRAM word, flags beat-order and out-of-phase writes, counts
// committed words, and sequences core start / run / ready from the load-done
// levels of the register bank.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   host_din     - host write data, channel c at [c*32 +: 32]
//   host_ena     - host port enable per channel
//   host_wea     - host write enable per channel
//   host_addra   - host byte address per channel, channel c at [c*HA_W +: HA_W]
//   load_done    - register-bank load-done levels per channel
//   core_done    - single-cycle pulse from the core at layer end
//   int_we       - internal BRAM write strobe per channel
//   int_addr     - internal word address per channel
//   int_din      - packed internal word per channel
//   core_start   - one-cycle core start pulse
//   gat_ready    - layer complete, held until load_done clears
//   load_err     - sticky errors: [c] beat order on channel c, [NUM_CH] write while busy
//   wr_cnt       - committed internal words per channel (saturating)
module gat_bram_load_ctrl #(
  parameter int unsigned TOP_WIDTH = 32,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BEATS     = 2,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned BL        = (BEATS > 1) ? $clog2(BEATS) : 0,
  parameter int unsigned HA_W      = ADDR_W + BL + 2,
  parameter int unsigned CNT_W     = ADDR_W + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*TOP_WIDTH-1:0] host_din,
  input  logic [NUM_CH-1:0]           host_ena,
  input  logic [NUM_CH-1:0]           host_wea,
  input  logic [NUM_CH*HA_W-1:0]      host_addra,
  input  logic [NUM_CH-1:0]           load_done,
  input  logic                        core_done,
  output logic [NUM_CH-1:0]           int_we,
  output logic [NUM_CH*ADDR_W-1:0]    int_addr,
  output logic [NUM_CH*DATA_W-1:0]    int_din,
  output logic                        core_start,
  output logic                        gat_ready,
  output logic [NUM_CH:0]             load_err,
  output logic [NUM_CH*CNT_W-1:0]     wr_cnt
);

  // Beat index storage is at least one bit wide so BEATS=1 still elaborates.
  localparam int unsigned BW     = (BL > 0) ? BL : 1;
  localparam int unsigned PACK_W = BEATS * TOP_WIDTH;
  localparam int unsigned LAST_B = BEATS - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;

  logic [NUM_CH-1:0] wr_c;
  logic [NUM_CH-1:0] acc_c;
  logic [NUM_CH-1:0] fin_c;
  logic              accept_st_c;
  logic              drop_c;
  logic              clr_c;

  logic [BW-1:0]     beat_c    [NUM_CH];
  logic [BW-1:0]     exp_nxt_c [NUM_CH];
  logic [ADDR_W-1:0] waddr_c   [NUM_CH];
  logic [PACK_W-1:0] pack_nxt_c[NUM_CH];

  logic [PACK_W-1:0] pack_reg  [NUM_CH];
  logic [BW-1:0]     exp_q     [NUM_CH];
  logic [ADDR_W-1:0] addr_q    [NUM_CH];
  logic [DATA_W-1:0] din_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_q     [NUM_CH];

  // Writes are only taken while the core is not being started or running.
  assign accept_st_c = (state == IDLE) || (state == LOAD) || (state == DONE);
  assign wr_c        = host_ena & host_wea;
  assign acc_c       = wr_c & {NUM_CH{accept_st_c}};
  assign drop_c      = (|wr_c) && !accept_st_c;
  assign clr_c       = (state == DONE) && (load_done == '0);

  // Per-channel address decode, beat insertion and next expected beat.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      beat_c[c]  = (BL > 0) ? BW'(host_addra[c*HA_W +: HA_W] >> 2) : '0;
      waddr_c[c] = ADDR_W'(host_addra[c*HA_W +: HA_W] >> (BL + 2));
      fin_c[c]   = acc_c[c] && (beat_c[c] == BW'(LAST_B));
      exp_nxt_c[c] = (beat_c[c] == BW'(LAST_B)) ? '0 : beat_c[c] + 1'b1;
      pack_nxt_c[c] = pack_reg[c];
      pack_nxt_c[c][beat_c[c]*TOP_WIDTH +: TOP_WIDTH] =
        host_din[c*TOP_WIDTH +: TOP_WIDTH];
    end
  end

  // Packing, commit, counters and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_we   <= '0;
      load_err <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pack_reg[c] <= '0;
        exp_q[c]    <= '0;
        addr_q[c]   <= '0;
        din_q[c]    <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      int_we <= fin_c;
      for (int c = 0; c < NUM_CH; c++) begin
        if (fin_c[c]) begin
          addr_q[c] <= waddr_c[c];
          din_q[c]  <= pack_nxt_c[c][DATA_W-1:0];
        end
      end
      if (clr_c) begin
        // Leaving DONE starts a fresh load session.
        load_err <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          pack_reg[c] <= '0;
          exp_q[c]    <= '0;
          cnt_q[c]    <= '0;
        end
      end else begin
        if (drop_c) begin
          load_err[NUM_CH] <= 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (acc_c[c]) begin
            pack_reg[c] <= pack_nxt_c[c];
            exp_q[c]    <= exp_nxt_c[c];
            if (beat_c[c] != exp_q[c]) begin
              load_err[c] <= 1'b1;
            end
          end
          if (fin_c[c] && (cnt_q[c] != '1)) begin
            cnt_q[c] <= cnt_q[c] + 1'b1;
          end
        end
      end
    end
  end

  // Load / start / run / ready sequencing with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      core_start <= 1'b0;
      gat_ready  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|acc_c) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          // A final beat this cycle commits next cycle, so hold START off
          // until the commit has gone out.
          if ((&load_done) && !(|fin_c)) begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (core_done) begin
            state     <= DONE;
            gat_ready <= 1'b1;
          end
        end
        DONE: begin
          if (load_done == '0) begin
            state     <= IDLE;
            gat_ready <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Flatten per-channel registers onto the output buses.
  always_comb begin
    int_addr = '0;
    int_din  = '0;
    wr_cnt   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int_addr[c*ADDR_W +: ADDR_W] = addr_q[c];
      int_din[c*DATA_W +: DATA_W]  = din_q[c];
      wr_cnt[c*CNT_W +: CNT_W]     = cnt_q[c];
    end
  end

endmodule
